// File: rtl/pipe_decode_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_decode_ctrl
// Purpose  : ID-stage decoder and ID/EX control register with hazard/flush
//            bubbling, multi-cycle multiply freeze and performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_decode_ctrl #(
  parameter int OP_LEN  = 4,
  parameter int EXE_LEN = 4,
  parameter int MUL_LAT = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_LEN-1:0]  op_code,
  input  logic               op_valid,
  input  logic               hazard_detected,
  input  logic               flush,
  output logic               stall_front,
  output logic               ex_valid,
  output logic [EXE_LEN-1:0] ex_cmd,
  output logic [1:0]         ex_branch_cmd,
  output logic               ex_branch_en,
  output logic               ex_is_imm,
  output logic               ex_st_or_bne,
  output logic               ex_wb_en,
  output logic               ex_mem_r_en,
  output logic               ex_mem_w_en,
  output logic               ex_is_comp,
  output logic               ex_is_mul,
  output logic               ex_mov_en,
  output logic               ex_is_clr,
  output logic               ex_is_jump,
  output logic               mul_busy,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   issued_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_SLL  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_COMP = 4'd6;
  localparam logic [3:0] OP_ADDI = 4'd7;
  localparam logic [3:0] OP_MOV  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd9;
  localparam logic [3:0] OP_LD   = 4'd10;
  localparam logic [3:0] OP_ST   = 4'd11;
  localparam logic [3:0] OP_BNE  = 4'd12;
  localparam logic [3:0] OP_JMP  = 4'd13;

  localparam logic [EXE_LEN-1:0] EXE_NOP = EXE_LEN'(0);
  localparam logic [EXE_LEN-1:0] EXE_ADD = EXE_LEN'(1);
  localparam logic [EXE_LEN-1:0] EXE_SUB = EXE_LEN'(2);
  localparam logic [EXE_LEN-1:0] EXE_AND = EXE_LEN'(3);
  localparam logic [EXE_LEN-1:0] EXE_SLL = EXE_LEN'(4);
  localparam logic [EXE_LEN-1:0] EXE_MUL = EXE_LEN'(5);

  localparam logic [3:0] MUL_WAIT_LOAD = 4'(MUL_LAT - 1);
  localparam bit         MUL_FREEZES   = (MUL_LAT > 1);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MUL_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [EXE_LEN-1:0] cmd;
    logic [1:0]         branch_cmd;
    logic               branch_en;
    logic               is_imm;
    logic               st_or_bne;
    logic               wb_en;
    logic               mem_r_en;
    logic               mem_w_en;
    logic               is_comp;
    logic               is_mul;
    logic               mov_en;
    logic               is_clr;
    logic               is_jump;
  } ctrl_t;

  state_t             state_q, state_d;
  logic [3:0]         mul_cnt_q, mul_cnt_d;
  ctrl_t              ex_q, ex_d;
  logic               illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0]   issued_cnt_q, issued_cnt_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;

  ctrl_t              dec;
  logic               op_legal;

  // Opcodes above 13 or with any upper bit set fall outside the legal range.
  assign op_legal = (op_code <= OP_LEN'(13));

  always_comb begin
    dec       = '0;
    dec.valid = 1'b1;
    case (op_code[3:0])
      OP_NOP:  ;
      OP_ADD:  begin dec.cmd = EXE_ADD; dec.wb_en = 1'b1; end
      OP_SUB:  begin dec.cmd = EXE_SUB; dec.wb_en = 1'b1; end
      OP_AND:  begin dec.cmd = EXE_AND; dec.wb_en = 1'b1; end
      OP_SLL:  begin dec.cmd = EXE_SLL; dec.wb_en = 1'b1; end
      OP_MUL:  begin dec.cmd = EXE_MUL; dec.wb_en = 1'b1; dec.is_mul = 1'b1; end
      OP_COMP: begin dec.cmd = EXE_SUB; dec.wb_en = 1'b1; dec.is_comp = 1'b1; end
      OP_ADDI: begin dec.cmd = EXE_ADD; dec.wb_en = 1'b1; dec.is_imm = 1'b1; end
      OP_MOV:  begin dec.cmd = EXE_NOP; dec.is_imm = 1'b1; dec.mov_en = 1'b1; end
      OP_CLR:  begin dec.cmd = EXE_NOP; dec.is_clr = 1'b1; end
      OP_LD: begin
        dec.cmd       = EXE_ADD;
        dec.wb_en     = 1'b1;
        dec.is_imm    = 1'b1;
        dec.st_or_bne = 1'b1;
        dec.mem_r_en  = 1'b1;
      end
      OP_ST: begin
        dec.cmd       = EXE_ADD;
        dec.is_imm    = 1'b1;
        dec.mem_w_en  = 1'b1;
        dec.st_or_bne = 1'b1;
      end
      OP_BNE: begin
        dec.is_imm     = 1'b1;
        dec.branch_en  = 1'b1;
        dec.branch_cmd = 2'd1;
        dec.st_or_bne  = 1'b1;
      end
      OP_JMP: begin
        dec.is_imm     = 1'b1;
        dec.branch_en  = 1'b1;
        dec.branch_cmd = 2'd2;
        dec.is_jump    = 1'b1;
      end
      default: dec = '0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    ex_d         = '0;
    illegal_op_d = 1'b0;
    issued_cnt_d = issued_cnt_q;
    bubble_cnt_d = bubble_cnt_q;

    if (state_q == ST_MUL_WAIT) begin
      // The multiply is older than any flush, so the wait always runs out.
      bubble_cnt_d = bubble_cnt_q + 1'b1;
      mul_cnt_d    = mul_cnt_q - 1'b1;
      if (mul_cnt_q == 4'd1) begin
        state_d = ST_RUN;
      end
    end else if (flush || hazard_detected) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end else if (op_valid) begin
      if (!op_legal) begin
        illegal_op_d = 1'b1;
        bubble_cnt_d = bubble_cnt_q + 1'b1;
      end else begin
        ex_d         = dec;
        issued_cnt_d = issued_cnt_q + 1'b1;
        if (dec.is_mul && MUL_FREEZES) begin
          state_d   = ST_MUL_WAIT;
          mul_cnt_d = MUL_WAIT_LOAD;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      mul_cnt_q    <= '0;
      ex_q         <= '0;
      illegal_op_q <= 1'b0;
      issued_cnt_q <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      ex_q         <= ex_d;
      illegal_op_q <= illegal_op_d;
      issued_cnt_q <= issued_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign mul_busy      = (state_q == ST_MUL_WAIT);
  assign stall_front   = mul_busy | (hazard_detected & ~flush);

  assign ex_valid      = ex_q.valid;
  assign ex_cmd        = ex_q.cmd;
  assign ex_branch_cmd = ex_q.branch_cmd;
  assign ex_branch_en  = ex_q.branch_en;
  assign ex_is_imm     = ex_q.is_imm;
  assign ex_st_or_bne  = ex_q.st_or_bne;
  assign ex_wb_en      = ex_q.wb_en;
  assign ex_mem_r_en   = ex_q.mem_r_en;
  assign ex_mem_w_en   = ex_q.mem_w_en;
  assign ex_is_comp    = ex_q.is_comp;
  assign ex_is_mul     = ex_q.is_mul;
  assign ex_mov_en     = ex_q.mov_en;
  assign ex_is_clr     = ex_q.is_clr;
  assign ex_is_jump    = ex_q.is_jump;
  assign illegal_op    = illegal_op_q;
  assign issued_cnt    = issued_cnt_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule
`default_nettype wire

// File: doc/pipe_decode_ctrl.md
Name: pipe_decode_ctrl

Overview:
Parametrised decode/control stage for the customised MIPS pipeline. It decodes the ID-stage opcode into the full control bundle and registers it as the ID/EX control register, so every output is a flop and no output can latch. It inserts bubbles on load-use hazards and on branch flush. It sequences a multi-cycle multiply by freezing the front end for MUL_LAT-1 cycles, and it counts issued instructions and bubbles for performance debug.

Parameters:
OP_LEN, 4, opcode width; bits above [3:0] must be zero for a legal opcode.
EXE_LEN, 4, EXE command width (minimum 3).
MUL_LAT, 3, multiply latency in EX cycles, valid range 1..15; 1 means a single-cycle multiply with no freeze.
CNT_W, 16, width of the performance counters.

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
op_code  in  OP_LEN  opcode from IF/ID
op_valid  in  1  IF/ID holds a real instruction
hazard_detected  in  1  load-use hazard from the hazard unit
flush  in  1  branch/jump taken, resolved in EX
stall_front  out  1  combinational; freezes PC and IF/ID
ex_valid  out  1  EX stage holds a real instruction
ex_cmd  out  EXE_LEN  ALU command
ex_branch_cmd  out  2  0 = none, 1 = BNE, 2 = JUMP
ex_branch_en, ex_is_imm, ex_st_or_bne, ex_wb_en, ex_mem_r_en, ex_mem_w_en, ex_is_comp, ex_is_mul, ex_mov_en, ex_is_clr, ex_is_jump  out  1 each  registered control flags
mul_busy  out  1  multiply wait in progress
illegal_op  out  1  one-cycle pulse, registered
issued_cnt  out  CNT_W  count of instructions issued to EX
bubble_cnt  out  CNT_W  count of bubbles inserted

Behaviour:
- Opcode encoding: NOP=0, ADD=1, SUB=2, AND=3, SLL=4, MUL=5, COMP=6, ADDI=7, MOV=8, CLR=9, LD=10, ST=11, BNE=12, JMP=13. Values 14, 15, and any value with a nonzero upper bit are illegal.
- EXE encoding: NOP=0, ADD=1, SUB=2, AND=3, SLL=4, MUL=5.
- Decode table (flags not listed are 0):
  - ADD, SUB, AND, SLL: cmd = matching EXE code, wb.
  - MUL: cmd = MUL, wb, is_mul.
  - COMP: cmd = SUB, wb, is_comp.
  - ADDI: cmd = ADD, wb, imm.
  - MOV: cmd = NOP, imm, mov_en.
  - CLR: cmd = NOP, is_clr.
  - LD: cmd = ADD, wb, imm, st_or_bne, mem_r.
  - ST: cmd = ADD, imm, mem_w, st_or_bne.
  - BNE: cmd = NOP, imm, branch_en, branch_cmd = 1, st_or_bne.
  - JMP: cmd = NOP, imm, branch_en, branch_cmd = 2, is_jump.
  - NOP: all zero.
- Bubble: every ex_* output is 0 and ex_valid is 0.
- Latency: one cycle. The opcode presented in cycle N appears on ex_* in cycle N+1.
- Priority each cycle: rst > flush > mul_wait > hazard_detected > decode.
  - rst: all outputs and counters go to 0 on the next edge; the FSM goes to RUN and the multiply counter is cleared. A reset during MUL_WAIT aborts the wait.
  - flush: EX loads a bubble; bubble_cnt increments. In RUN, no decode happens. In MUL_WAIT, the counter keeps decrementing (the multiply is older than the branch).
  - hazard_detected in RUN: EX loads a bubble, stall_front = 1, bubble_cnt increments.
- FSM states RUN and MUL_WAIT:
  - RUN to MUL_WAIT: a MUL is issued and MUL_LAT > 1; mul_cnt loads MUL_LAT-1.
  - MUL_WAIT: EX loads a bubble each cycle, mul_cnt decrements, bubble_cnt increments, hazard_detected is ignored.
  - MUL_WAIT to RUN: on the edge where mul_cnt goes 1 to 0.
  - mul_busy = (state == MUL_WAIT).
- stall_front = mul_busy | (hazard_detected & ~flush), combinational.
- Issue: in RUN with no flush and no hazard, and op_valid = 1 with a legal opcode: EX loads the decode, ex_valid = 1, issued_cnt increments. NOP counts as issued.
- op_valid = 0 in RUN: EX loads a bubble; neither counter changes.
- Illegal opcode with op_valid = 1 in RUN: EX loads a bubble, illegal_op pulses 1 on the next cycle, bubble_cnt increments.
- Counters wrap modulo 2^CNT_W and never saturate.
- Simultaneous MUL with hazard_detected: the hazard wins, no issue, and the FSM stays in RUN.

Test Plan:
1. rst=1 for 2 cycles with op_code=1, op_valid=1 -> all ex_* = 0, counters = 0. Release rst -> ex_cmd=1, ex_wb_en=1, ex_valid=1 one cycle later; issued_cnt=1.
2. Stream LD, ST, BNE, JMP (10, 11, 12, 13) -> flags match the decode table each cycle. For example, ST gives ex_mem_w_en=1, ex_wb_en=0, ex_st_or_bne=1; JMP gives ex_branch_cmd=2, ex_is_jump=1.
3. MUL with MUL_LAT=3 -> ex_is_mul=1 for one cycle, then 2 bubbles. mul_busy and stall_front are high for exactly 2 cycles, then the next opcode issues; bubble_cnt increases by 2. Repeat with MUL_LAT=1 -> no stall.
4. ADD with hazard_detected=1 for one cycle -> ex_valid=0 and stall_front=1 that cycle. ADD issues the following cycle; bubble_cnt=1.
5. flush=1 together with hazard_detected=1 and op ADDI -> bubble, stall_front=0. Flush during MUL_WAIT with MUL_LAT=4 -> the wait still ends after 3 cycles.
6. op_code=14 with op_valid=1 -> bubble, illegal_op=1 for exactly one cycle. rst asserted mid-MUL_WAIT -> mul_busy=0 on the next edge.
